// File: rtl/freq_meter_pkg.sv
// Shared clock-design definitions: gate-window FSM encoding and the system clock rate.
package freq_meter_pkg;

    localparam int unsigned CLK_HZ = 50_000_000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GATE  = 2'd1,
        ST_LATCH = 2'd2
    } fm_state_t;

endpackage

// File: rtl/sync_edge_det.sv
// Two-flop synchronizer for an asynchronous level, followed by a one-cycle rising-edge pulse.
module sync_edge_det (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_rise
);

    logic r_s1;
    logic r_s2;
    logic r_s3;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_s3 <= 1'b0;
        end else begin
            r_s1 <= i_d;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    // r_s3 only delays the already-synchronized level, so the pulse is clean.
    assign o_rise = r_s2 & ~r_s3;

endmodule

// File: rtl/freq_meter.sv
// Counts rising edges of an asynchronous input over a fixed window of clk cycles
// and publishes the count once per window.
module freq_meter
    import freq_meter_pkg::*;
#(
    parameter int unsigned GATE_CYCLES = CLK_HZ,
    parameter int unsigned CNT_W       = 27
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_en,
    input  logic             i_sig_in,
    output logic [CNT_W-1:0] o_freq,
    output logic             o_valid,
    output logic             o_ovf,
    output logic             o_busy
);

    localparam int unsigned GATE_W = $clog2(GATE_CYCLES);
    localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);

    // Returns {saturated, next value}; the count sticks at all-ones once full.
    function automatic logic [CNT_W:0] sat_inc(input logic [CNT_W-1:0] v);
        if (&v) begin
            return {1'b1, v};
        end
        return {1'b0, v + CNT_W'(1)};
    endfunction

    fm_state_t         r_state;
    logic [GATE_W-1:0] r_gate_cnt;
    logic [CNT_W-1:0]  r_edge_cnt;
    logic              r_sat;
    logic [CNT_W-1:0]  r_freq;
    logic              r_valid;
    logic              r_ovf;
    logic              r_busy;

    logic              w_rise;
    logic [CNT_W:0]    w_inc;

    sync_edge_det u_sync (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_d     (i_sig_in),
        .o_rise  (w_rise)
    );

    assign w_inc = sat_inc(r_edge_cnt);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= ST_IDLE;
            r_gate_cnt <= '0;
            r_edge_cnt <= '0;
            r_sat      <= 1'b0;
            r_freq     <= '0;
            r_valid    <= 1'b0;
            r_ovf      <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_gate_cnt <= '0;
                    r_edge_cnt <= '0;
                    r_sat      <= 1'b0;
                    if (i_en) begin
                        r_state <= ST_GATE;
                        r_busy  <= 1'b1;
                    end else begin
                        r_busy  <= 1'b0;
                    end
                end

                ST_GATE: begin
                    if (!i_en) begin
                        // Abort: discard the partial window, keep the last published result.
                        r_state    <= ST_IDLE;
                        r_busy     <= 1'b0;
                        r_gate_cnt <= '0;
                        r_edge_cnt <= '0;
                        r_sat      <= 1'b0;
                    end else begin
                        if (w_rise) begin
                            r_edge_cnt <= w_inc[CNT_W-1:0];
                            if (w_inc[CNT_W]) begin
                                r_sat <= 1'b1;
                            end
                        end
                        if (r_gate_cnt == GATE_LAST) begin
                            r_state <= ST_LATCH;
                            r_busy  <= 1'b0;
                        end else begin
                            r_gate_cnt <= r_gate_cnt + GATE_W'(1);
                        end
                    end
                end

                ST_LATCH: begin
                    // Edges seen in this cycle are intentionally dropped.
                    r_freq     <= r_edge_cnt;
                    r_ovf      <= r_sat;
                    r_valid    <= 1'b1;
                    r_gate_cnt <= '0;
                    r_edge_cnt <= '0;
                    r_sat      <= 1'b0;
                    if (i_en) begin
                        r_state <= ST_GATE;
                        r_busy  <= 1'b1;
                    end else begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign o_freq  = r_freq;
    assign o_valid = r_valid;
    assign o_ovf   = r_ovf;
    assign o_busy  = r_busy;

endmodule
